// File: rtl/dsc_pkg.sv
// Shared types and sizing helpers for the deterministic stochastic-computing multiplier sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dsc_pkg;

  // Default operand geometry of the multiplier this sequencer drives.
  localparam int DEF_DATA_WIDTH = 5;
  localparam int DEF_NUM_INPUTS = 2;
  localparam int DEF_RUN_SLACK  = 4;
  localparam int PROD_W         = DEF_DATA_WIDTH * DEF_NUM_INPUTS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // Cycles a full multiplier run takes: the stream generators sweep every
  // combination of the concatenated operand bits once.
  function automatic int run_len(input int prod_w);
    return 1 << prod_w;
  endfunction

endpackage

// File: rtl/dsc_run_watchdog.sv
// Saturating run-length counter that flags a multiplier run which overstays its limit.
// Latency: count updates one cycle after en; expired is combinational from the count.
// Backpressure: none; counts whenever enabled, holds at all-ones instead of wrapping.
//
// Ports: clk, rst (async active-low), clr (sync zero), en (count this cycle),
//        expired (this cycle's increment brings the count to LIMIT, or it is already past).
module dsc_run_watchdog #(
  parameter int CNT_W = 11,
  parameter int LIMIT = 1028
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Looking one increment ahead lets the FSM leave RUN on exactly the
  // LIMIT-th run cycle rather than one cycle later.
  assign expired = (count >= LAST);

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequencer wrapping the serial stochastic multiplier: load operands, clear, run, capture product.
// Latency: op accept to res_valid = 1 (CLEAR) + run cycles + 1 (SETTLE) + 1; timeout skips SETTLE.
// Backpressure: op_ready only in IDLE; result held in HOLD until res_ready, no overlap of runs.
//
// Ports: op_valid/op_ready/op_data     operand vector in (operand i at [i*DATA_WIDTH +: DATA_WIDTH])
//        mul_clr/mul_en/mul_operand    control and operands to the multiplier
//        mul_product/mul_done          count-of-ones product and completion from the multiplier
//        res_valid/res_ready/res_data/res_err  result out (res_err=1: watchdog timeout, data=0)
//        busy                          high whenever the FSM is not in IDLE
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int RUN_SLACK  = DEF_RUN_SLACK
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] op_data,
  output logic                             mul_clr,
  output logic                             mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_operand,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_product,
  input  logic                             mul_done,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] res_data,
  output logic                             res_err,
  output logic                             busy
);

  localparam int PW    = DATA_WIDTH * NUM_INPUTS;
  localparam int LIMIT = run_len(PW) + RUN_SLACK;

  state_t state;
  logic   wd_expired;

  // The watchdog is zeroed during CLEAR so every RUN starts counting from 0.
  dsc_run_watchdog #(
    .CNT_W (PW + 1),
    .LIMIT (LIMIT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == CLEAR),
    .en      (state == RUN),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_ready    <= 1'b1;
      mul_clr     <= 1'b1;
      mul_en      <= 1'b0;
      mul_operand <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            mul_operand <= op_data;
            op_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= CLEAR;
          end
        end

        CLEAR: begin
          mul_clr <= 1'b0;
          mul_en  <= 1'b1;
          state   <= RUN;
        end

        RUN: begin
          // Completion is checked first so a done coinciding with expiry
          // still yields a good result.
          if (mul_done) begin
            mul_en <= 1'b0;
            state  <= SETTLE;
          end else if (wd_expired) begin
            mul_en    <= 1'b0;
            mul_clr   <= 1'b1;
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end

        SETTLE: begin
          // Clear stays low here so the final count is still present to capture.
          res_data  <= mul_product;
          res_err   <= 1'b0;
          res_valid <= 1'b1;
          mul_clr   <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          op_ready  <= 1'b1;
          mul_clr   <= 1'b1;
          mul_en    <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Self-checking bench for dsc_mul_seq with a behavioural deterministic SC multiplier and a done stub.
// Latency: n/a.
// Backpressure: exercised by holding res_ready low in HOLD.
module tb_dsc_mul_seq;

  localparam int DW    = 5;
  localparam int NI    = 2;
  localparam int PW    = DW * NI;
  localparam int SLACK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [PW-1:0] op_data = '0;
  logic          mul_clr;
  logic          mul_en;
  logic [PW-1:0] mul_operand;
  logic [PW-1:0] mul_product;
  logic          mul_done;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [PW-1:0] res_data;
  logic          res_err;
  logic          busy;

  always #5 clk = ~clk;

  dsc_mul_seq #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .RUN_SLACK  (SLACK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_data     (op_data),
    .mul_clr     (mul_clr),
    .mul_en      (mul_en),
    .mul_operand (mul_operand),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy)
  );

  // Ideal multiplier: clock-division streams, operand 0 compared with the low
  // counter bits, operand 1 with the high bits; done registers on counter wrap.
  logic [PW-1:0] m_cnt, m_prod;
  logic          m_done;
  always @(posedge clk or negedge rst) begin
    if (!rst || mul_clr) begin
      m_cnt  <= '0;
      m_prod <= '0;
      m_done <= 1'b0;
    end else if (mul_en && !m_done) begin
      if ((m_cnt[DW-1:0] < mul_operand[DW-1:0]) && (m_cnt[PW-1:DW] < mul_operand[PW-1:DW]))
        m_prod <= m_prod + 1'b1;
      m_cnt <= m_cnt + 1'b1;
      if (m_cnt == '1) m_done <= 1'b1;
    end
  end

  // Stub multiplier: done raised on a chosen RUN cycle (0 = never).
  logic          stub_mode = 1'b0;
  logic          stub_done = 1'b0;
  int            stub_run = 0;
  int            stub_done_at = 0;
  logic [PW-1:0] stub_prod = 10'h2A5;
  always @(negedge clk) begin
    if (!stub_mode || op_ready) begin
      stub_run  = 0;
      stub_done = 1'b0;
    end else if (mul_en) begin
      stub_run = stub_run + 1;
      if (stub_run == stub_done_at) stub_done = 1'b1;
    end
  end

  assign mul_done    = stub_mode ? stub_done : m_done;
  assign mul_product = stub_mode ? stub_prod : m_prod;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          e;
  } exp_t;

  exp_t exp_q[$];
  time  accept_time;
  int   checks = 0;
  int   errors = 0;

  task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [PW-1:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    @(negedge clk);
    while (op_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_op_ready got=%b want=1", op_ready);
      return;
    end
    op_valid = 1'b1;
    op_data  = {b, a};
    @(posedge clk);
    accept_time = $time;
    exp_q.push_back('{d: exp_d, e: exp_e});
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (mul_operand !== {b, a} || busy !== 1'b1 || mul_clr !== 1'b1 || mul_en !== 1'b0) begin
      errors++;
      $display("FAIL op_latch got operand=%0h busy=%b clr=%b en=%b want operand=%0h busy=1 clr=1 en=0",
               mul_operand, busy, mul_clr, mul_en, {b, a});
    end
  endtask

  // Waits for res_valid, checks it against the scoreboard head, optionally
  // holds res_ready low, then completes the handshake.
  task automatic wait_result(input string name, input int exp_lat, input int hold_cycles,
                             input int exp_run);
    int   n, lat, ready_bad, hold_bad;
    bit   seen;
    exp_t ex;
    n = 0; seen = 0; ready_bad = 0; hold_bad = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (res_valid === 1'b1) seen = 1;
      else if (op_ready !== 1'b0) ready_bad++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_res_valid_timeout got=0 want=1 within 3000 cycles", name);
      return;
    end
    lat = int'(($time - 5 - accept_time) / 10);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (ready_bad != 0) begin
      errors++;
      $display("FAIL %s_op_ready_during_run got=%0d cycles high want=0", name, ready_bad);
    end
    if (exp_run >= 0) begin
      checks++;
      if (stub_run != exp_run) begin
        errors++;
        $display("FAIL %s_run_cycles got=%0d want=%0d", name, stub_run, exp_run);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got=empty want=entry", name);
      return;
    end
    ex = exp_q.pop_front();
    checks++;
    if (res_data !== ex.d || res_err !== ex.e) begin
      errors++;
      $display("FAIL %s_result got data=%0d err=%b want data=%0d err=%b",
               name, res_data, res_err, ex.d, ex.e);
    end
    if (hold_cycles > 0) begin
      for (int i = 0; i < hold_cycles; i++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_data !== ex.d || op_ready !== 1'b0 ||
            mul_en !== 1'b0 || mul_clr !== 1'b1) hold_bad++;
      end
      checks++;
      if (hold_bad != 0) begin
        errors++;
        $display("FAIL %s_hold_stable got=%0d bad cycles want=0", name, hold_bad);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release got valid=%b ready=%b busy=%b want valid=0 ready=1 busy=0",
               name, res_valid, op_ready, busy);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if (op_ready !== 1'b1 || mul_clr !== 1'b1 || mul_en !== 1'b0 || mul_operand !== '0 ||
        res_valid !== 1'b0 || res_data !== '0 || res_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b clr=%b en=%b opnd=%0h val=%b dat=%0h err=%b busy=%b want 1 1 0 0 0 0 0 0",
               op_ready, mul_clr, mul_en, mul_operand, res_valid, res_data, res_err, busy);
    end
    checks++;
    if (dut.u_wd.count !== '0) begin
      errors++;
      $display("FAIL reset_watchdog got=%0d want=0", dut.u_wd.count);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    send_op(5'd3, 5'd7, 10'd21, 1'b0);
    wait_result("single_3x7", 1027, 0, -1);
  endtask

  task automatic test_extremes();
    int bad;
    send_op(5'd0, 5'd31, 10'd0, 1'b0);
    // Offers during the run must be ignored and must not disturb the operands.
    bad = 0;
    op_valid = 1'b1;
    op_data  = '1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_operand !== {5'd31, 5'd0} || op_ready !== 1'b0) bad++;
    end
    op_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL extremes_no_overwrite got=%0d bad cycles want=0", bad);
    end
    wait_result("extreme_0x31", 1027, 0, -1);
    send_op(5'd31, 5'd31, 10'd961, 1'b0);
    wait_result("extreme_31x31", 1027, 0, -1);
  endtask

  task automatic test_backpressure();
    send_op(5'd12, 5'd9, 10'd108, 1'b0);
    wait_result("backpressure", 1027, 50, -1);
  endtask

  task automatic test_timeout();
    stub_mode    = 1'b1;
    stub_done_at = 0;
    send_op(5'd4, 5'd4, 10'd0, 1'b1);
    wait_result("timeout", 1029, 3, 1024 + SLACK);
    stub_mode = 1'b0;
  endtask

  task automatic test_done_race();
    stub_mode    = 1'b1;
    stub_done_at = 1024 + SLACK;
    send_op(5'd2, 5'd2, 10'h2A5, 1'b0);
    wait_result("done_vs_expiry", 1030, 0, 1024 + SLACK);
    stub_mode    = 1'b0;
    stub_done_at = 0;
  endtask

  task automatic test_rst_mid_run();
    int n, seen;
    send_op(5'd3, 5'd3, 10'd9, 1'b0);
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (mul_en === 1'b1) n++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || mul_clr !== 1'b1 || mul_en !== 1'b0 || mul_operand !== '0 ||
        res_valid !== 1'b0 || res_data !== '0 || res_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs got rdy=%b clr=%b en=%b opnd=%0h val=%b dat=%0h err=%b busy=%b want 1 1 0 0 0 0 0 0",
               op_ready, mul_clr, mul_en, mul_operand, res_valid, res_data, res_err, busy);
    end
    checks++;
    if (dut.u_wd.count !== '0) begin
      errors++;
      $display("FAIL midrun_reset_watchdog got=%0d want=0", dut.u_wd.count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_no_result got=%0d valid cycles want=0", seen);
    end
    exp_q.delete();
    send_op(5'd5, 5'd6, 10'd30, 1'b0);
    wait_result("after_reset_5x6", 1027, 0, -1);
  endtask

  task automatic test_back_to_back();
    send_op(5'd1, 5'd1, 10'd1, 1'b0);
    wait_result("b2b_1x1", 1027, 0, -1);
    send_op(5'd31, 5'd1, 10'd31, 1'b0);
    wait_result("b2b_31x1", 1027, 0, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_backpressure();
    test_timeout();
    test_done_race();
    test_rst_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/dsc_mul_seq.md
Name: dsc_mul_seq

Overview:
- Sequencer that sits directly upstream and downstream of the serial deterministic stochastic-computing multiplier.
- Accepts operand vectors over a valid/ready handshake and registers them onto the multiplier's binary inputs.
- Clears the multiplier, enables it for one full run, then captures its count-of-ones product when the multiplier signals done.
- Presents the product over a valid/ready handshake, with a watchdog that flags a run which never completes.

Parameters:
- DATA_WIDTH, 5, bit width of each operand.
- NUM_INPUTS, 2, number of operands per multiplication.
- RUN_SLACK, 4, extra cycles beyond 2^(DATA_WIDTH*NUM_INPUTS) before the watchdog fires.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand vector offered.
- op_ready  out  1  sequencer can accept an operand vector.
- op_data  in  NUM_INPUTS*DATA_WIDTH  operands; operand i is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- mul_clr  out  1  active-high clear, wired to the multiplier reset.
- mul_en  out  1  multiplier enable.
- mul_operand  out  NUM_INPUTS*DATA_WIDTH  registered operands driven to the multiplier binary inputs.
- mul_product  in  NUM_INPUTS*DATA_WIDTH  multiplier count output.
- mul_done  in  1  multiplier completion (final stream-generator overflow).
- res_valid  out  1  product available.
- res_ready  in  1  consumer accepts the product.
- res_data  out  NUM_INPUTS*DATA_WIDTH  captured product.
- res_err  out  1  qualifies res_data; 1 = watchdog timeout, data invalid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - op_ready=1; mul_clr=1; mul_en=0; mul_operand=0.
  - res_valid=0; res_data=0; res_err=0; busy=0.
  - Watchdog counter = 0.
- FSM states: IDLE, CLEAR, RUN, SETTLE, HOLD.
- IDLE:
  - op_ready=1, mul_clr=1.
  - On op_valid&&op_ready: latch op_data into mul_operand and go to CLEAR.
- CLEAR (exactly 1 cycle):
  - mul_clr=1, mul_en=0, watchdog=0.
  - Next state: RUN.
- RUN:
  - mul_clr=0, mul_en=1; watchdog increments each cycle.
  - mul_done sampled high: go to SETTLE.
  - Watchdog reaches 2^(DATA_WIDTH*NUM_INPUTS)+RUN_SLACK before done: capture res_data=0, res_err=1, go to HOLD.
- SETTLE (exactly 1 cycle):
  - mul_en=0, so the final AND-count registers.
  - Capture res_data=mul_product and res_err=0; go to HOLD.
- HOLD:
  - res_valid=1; res_data and res_err are stable.
  - mul_en=0; mul_clr=1, so the multiplier holds in clear.
  - On res_valid&&res_ready: res_valid falls next cycle and the FSM returns to IDLE.
- Back-to-back operation: a new operand is accepted no earlier than the cycle after the result handshake completes, so there is no overlap.
- Latency:
  - op accept to res_valid = 1 (CLEAR) + run cycles + 1 (SETTLE) + 1.
  - For an ideal multiplier with defaults this is 2^10 + 3 cycles.
- op_ready is 0 in every state except IDLE; op_valid outside IDLE is ignored, and operands are not overwritten.
- mul_done high while not in RUN is ignored.
- mul_done and watchdog expiry in the same cycle: done wins, and res_err=0.
- Watchdog width is DATA_WIDTH*NUM_INPUTS+1 bits; it saturates and never wraps.
- Reset asserted mid-run aborts immediately to the reset values; no result is produced.
- busy=1 in CLEAR, RUN, SETTLE and HOLD.

Decomposition:
- Shared package dsc_pkg holds:
  - the state enum typedef (IDLE/CLEAR/RUN/SETTLE/HOLD);
  - localparam PROD_W = DATA_WIDTH*NUM_INPUTS;
  - the function run_len(PROD_W) returning 2^PROD_W.
- The watchdog is a natural sub-module: dsc_run_watchdog (clear, enable, saturating count, expired flag).
- The FSM and the result register stay in dsc_mul_seq.

Test Plan:
- Single run, ideal multiplier instance (DATA_WIDTH=5, NUM_INPUTS=2), ops 3 and 7:
  - res_valid rises 1027 cycles after op accept;
  - res_data=21, res_err=0.
- Extremes 0×31 and 31×31:
  - res_data=0, then res_data=961;
  - op_ready=0 throughout each run.
- Backpressure: hold res_ready=0 for 50 cycles in HOLD:
  - res_data stays stable, op_ready=0, mul_en=0;
  - releasing res_ready returns the FSM to IDLE with op_ready=1 on the next cycle.
- Stubbed multiplier with mul_done tied 0:
  - after 1024+4 RUN cycles, res_valid=1, res_err=1, res_data=0.
- mul_done forced in the same cycle as watchdog expiry:
  - res_err=0, res_data=mul_product.
- rst pulsed low mid-RUN (cycle 500):
  - all outputs return to reset values asynchronously; no res_valid;
  - a following op (5, 6) yields res_data=30.
